alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 142 ++++++++++++++
 tb/tb_alu_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for a shared, externally muxed ALU.
// One transaction at a time: IDLE grants a requester and latches its
// opcode/operands onto alu_sel/alu_a/alu_b, EXEC waits LAT cycles for the ALU
// result, RESP holds the result until the winning requester consumes it.
//
// Parameters:
//   BITS - operand/result width
//   LAT  - ALU result latency in cycles after operands are driven (1..7)
//
// Ports:
//   clk, rst_n                   - clock, asynchronous active-low reset
//   req_valid[1:0] / req_ready   - per-requester request handshake
//   req_op0/1, req_a0/b0/a1/b1   - per-requester opcode and operands
//   rsp_valid[1:0] / rsp_ready   - per-requester response handshake
//   rsp_data, rsp_err            - shared result; err = opcode above 8
//   alu_sel, alu_a, alu_b        - drive the external ALU
//   alu_result                   - external ALU mux output
//   busy                         - high whenever not IDLE
//
// Build option:
//   ALU_ARB_ROUND_ROBIN_EN - when defined, simultaneous requests alternate
//   between requesters; otherwise requester 0 always wins a tie.
module alu_arbiter #(
    parameter int unsigned BITS = 32,
    parameter int unsigned LAT  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [3:0]      req_op0,
    input  logic [3:0]      req_op1,
    input  logic [BITS-1:0] req_a0,
    input  logic [BITS-1:0] req_b0,
    input  logic [BITS-1:0] req_a1,
    input  logic [BITS-1:0] req_b1,
    output logic [1:0]      rsp_valid,
    input  logic [1:0]      rsp_ready,
    output logic [BITS-1:0] rsp_data,
    output logic            rsp_err,
    output logic [3:0]      alu_sel,
    output logic [BITS-1:0] alu_a,
    output logic [BITS-1:0] alu_b,
    input  logic [BITS-1:0] alu_result,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    localparam logic [2:0] CNT_LAST = 3'(LAT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] cnt;
    logic       winner;     // requester owning the current transaction
    logic       grant_id;   // requester that would win this cycle
    logic       accept;
    logic       cnt_done;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic last_grant;

    // On a tie, favour the requester not served last; otherwise whoever asks.
    always_comb begin
        if (req_valid == 2'b11) grant_id = ~last_grant;
        else                    grant_id = ~req_valid[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      last_grant <= 1'b1;
        else if (accept) last_grant <= grant_id;
    end
`else
    // Fixed priority: requester 0 wins whenever it is asking.
    always_comb grant_id = ~req_valid[0];
`endif

    // rst_n gating keeps req_ready low while reset is held even though the
    // state register already reads IDLE.
    assign accept   = rst_n && (state == IDLE) && (req_valid != 2'b00);
    assign cnt_done = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    req_ready = grant_id ? 2'b10 : 2'b01;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                busy = 1'b1;
                if (cnt_done) state_nxt = RESP;
            end
            RESP: begin
                busy      = 1'b1;
                rsp_valid = winner ? 2'b10 : 2'b01;
                // Only the winner's consume strobe ends the transaction.
                if (rsp_ready[winner]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            winner   <= 1'b0;
            alu_sel  <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else if (accept) begin
            cnt     <= '0;
            winner  <= grant_id;
            alu_sel <= grant_id ? req_op1 : req_op0;
            alu_a   <= grant_id ? req_a1  : req_a0;
            alu_b   <= grant_id ? req_b1  : req_b0;
        end else if (state == EXEC) begin
            cnt <= cnt + 3'd1;
            if (cnt_done) begin
                rsp_data <= alu_result;
                rsp_err  <= (alu_sel > 4'd8);
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: one LAT=1 instance for the main flow and
// one LAT=3 instance for the long-latency / error-opcode case.
module tb_alu_arbiter;

    localparam int unsigned BITS = 32;

    typedef struct packed {
        logic [1:0]  who;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // LAT=1 instance
    logic [1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
    logic [3:0]      req_op0, req_op1, alu_sel;
    logic [BITS-1:0] req_a0, req_b0, req_a1, req_b1;
    logic [BITS-1:0] rsp_data, alu_a, alu_b, alu_result;
    logic            rsp_err, busy;

    // LAT=3 instance
    logic [1:0]      req_valid3, req_ready3, rsp_valid3, rsp_ready3;
    logic [3:0]      req_op0_3, req_op1_3, alu_sel3;
    logic [BITS-1:0] req_a0_3, req_b0_3, req_a1_3, req_b1_3;
    logic [BITS-1:0] rsp_data3, alu_a3, alu_b3, alu_result3;
    logic            rsp_err3, busy3;
    logic [BITS-1:0] pipe3_s1 = '0, pipe3_s2 = '0;

    alu_arbiter #(.BITS(BITS), .LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op0(req_op0), .req_op1(req_op1),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .busy(busy)
    );

    alu_arbiter #(.BITS(BITS), .LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .req_op0(req_op0_3), .req_op1(req_op1_3),
        .req_a0(req_a0_3), .req_b0(req_b0_3), .req_a1(req_a1_3), .req_b1(req_b1_3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_data(rsp_data3), .rsp_err(rsp_err3),
        .alu_sel(alu_sel3), .alu_a(alu_a3), .alu_b(alu_b3),
        .alu_result(alu_result3), .busy(busy3)
    );

    // Reference ALU result mux.
    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            4'd7:    return a;
            4'd8:    return b;
            default: return 32'hBAD0_0000 | {28'd0, op};
        endcase
    endfunction

    always_comb alu_result = alu_ref(alu_sel, alu_a, alu_b);

    // Three-cycle ALU: result is only correct LAT edges after operands change.
    always @(posedge clk) begin
        pipe3_s1 <= alu_ref(alu_sel3, alu_a3, alu_b3);
        pipe3_s2 <= pipe3_s1;
    end
    assign alu_result3 = pipe3_s2;

    rsp_t       rsp_q[$], rsp_q3[$];
    logic [1:0] gnt_q[$], gnt_q3[$];
    int         pass_cnt  = 0;
    int         total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitors: pop expectations whenever the DUT grants or completes.
    rsp_t       e1, e3;
    logic [1:0] g1, g3;

    always @(negedge clk) begin
        if (rst_n) begin
            if (req_ready != 2'b00) begin
                if (gnt_q.size() == 0) check("unexpected_grant", req_ready, 2'b00);
                else begin
                    g1 = gnt_q.pop_front();
                    check("grant", req_ready, g1);
                end
            end
            if ((rsp_valid & rsp_ready) != 2'b00) begin
                if (rsp_q.size() == 0) check("unexpected_rsp", rsp_valid, 2'b00);
                else begin
                    e1 = rsp_q.pop_front();
                    check("rsp_valid", rsp_valid, e1.who);
                    check("rsp_data", rsp_data, e1.data);
                    check("rsp_err", rsp_err, e1.err);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (req_ready3 != 2'b00) begin
                if (gnt_q3.size() == 0) check("unexpected_grant3", req_ready3, 2'b00);
                else begin
                    g3 = gnt_q3.pop_front();
                    check("grant3", req_ready3, g3);
                end
            end
            if ((rsp_valid3 & rsp_ready3) != 2'b00) begin
                if (rsp_q3.size() == 0) check("unexpected_rsp3", rsp_valid3, 2'b00);
                else begin
                    e3 = rsp_q3.pop_front();
                    check("rsp_valid3", rsp_valid3, e3.who);
                    check("rsp_data3", rsp_data3, e3.data);
                    check("rsp_err3", rsp_err3, e3.err);
                end
            end
        end
    end

    task automatic wait_accept(input bit use3);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((use3 ? req_ready3 : req_ready) != 2'b00) return;
        end
        total_cnt++;
        $display("FAIL accept_timeout: no req_ready within 20 cycles (dut%0d)", use3 ? 3 : 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        req_valid  = 2'b11; rsp_ready  = 2'b11;
        req_op0    = 4'd3;  req_op1    = 4'd5;
        req_a0     = 32'h11; req_b0    = 32'h22; req_a1 = 32'h33; req_b1 = 32'h44;
        req_valid3 = 2'b00; rsp_ready3 = 2'b11;
        req_op0_3  = '0; req_op1_3 = '0;
        req_a0_3   = '0; req_b0_3  = '0; req_a1_3 = '0; req_b1_3 = '0;

        // Reset values, with both requests asserted during reset.
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_rsp_valid", rsp_valid, 2'b00);
        check("rst_alu_sel", alu_sel, 4'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_err", rsp_err, 1'b0);
        req_valid = 2'b00;
        @(posedge clk); #1 rst_n = 1'b1;

        // LAT=3, requester 1, out-of-range opcode 12.
        req_valid3 = 2'b10; req_op1_3 = 4'd12; req_a1_3 = 32'd7; req_b1_3 = 32'd9;
        gnt_q3.push_back(2'b10);
        rsp_q3.push_back('{who: 2'b10, data: 32'hBAD0_000C, err: 1'b1});
        wait_accept(1'b1);
        @(posedge clk); #1 req_valid3 = 2'b00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("lat3_alu_sel_held", alu_sel3, 4'd12);
            check("lat3_no_early_rsp", rsp_valid3, 2'b00);
        end
        @(negedge clk);
        check("lat3_rsp_at_accept_plus4", rsp_valid3, 2'b10);
        repeat (2) @(negedge clk);

        // Both requesters held valid for four transactions.
        req_op0 = 4'd0; req_a0 = 32'd10;  req_b0 = 32'd20;
        req_op1 = 4'd1; req_a1 = 32'd100; req_b1 = 32'd1;
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
            gnt_q.push_back((i % 2 == 0) ? 2'b01 : 2'b10);
            rsp_q.push_back((i % 2 == 0) ? rsp_t'('{who: 2'b01, data: 32'd30, err: 1'b0})
                                         : rsp_t'('{who: 2'b10, data: 32'd99, err: 1'b0}));
`else
            gnt_q.push_back(2'b01);
            rsp_q.push_back('{who: 2'b01, data: 32'd30, err: 1'b0});
`endif
        end
        @(posedge clk); #1 req_valid = 2'b11;
        g = 0;
        for (int i = 0; i < 60 && g < 4; i++) begin
            @(negedge clk);
            if (req_ready != 2'b00) g++;
        end
        if (g < 4) begin
            total_cnt++;
            $display("FAIL tie_grant_timeout: got %0d grants expected 4", g);
        end
        @(posedge clk); #1 req_valid = 2'b00;
        repeat (4) @(negedge clk);

        // LAT=1, requester 0, AND of 5 and 3; request dropped right after accept.
        req_op0 = 4'd2; req_a0 = 32'd5; req_b0 = 32'd3;
        gnt_q.push_back(2'b01);
        rsp_q.push_back('{who: 2'b01, data: 32'd1, err: 1'b0});
        @(posedge clk); #1 req_valid = 2'b01;
        wait_accept(1'b0);
        @(posedge clk); #1 req_valid = 2'b00;
        @(negedge clk);
        check("lat1_alu_sel", alu_sel, 4'd2);
        check("lat1_no_early_rsp", rsp_valid, 2'b00);
        @(negedge clk);
        check("lat1_rsp_at_accept_plus2", rsp_valid, 2'b01);
        repeat (2) @(negedge clk);

        // Stalled response: non-winner consume ignored, other requester waits.
        rsp_ready = 2'b10;
        req_op0 = 4'd4; req_a0 = 32'd6; req_b0 = 32'd3;
        gnt_q.push_back(2'b01);
        rsp_q.push_back('{who: 2'b01, data: 32'd5, err: 1'b0});
        gnt_q.push_back(2'b10);
        rsp_q.push_back('{who: 2'b10, data: 32'd15, err: 1'b0});
        @(posedge clk); #1 req_valid = 2'b01;
        wait_accept(1'b0);
        @(posedge clk); #1 req_valid = 2'b10;
        req_op1 = 4'd0; req_a1 = 32'd7; req_b1 = 32'd8;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_rsp_valid", rsp_valid, 2'b01);
            check("stall_rsp_data", rsp_data, 32'd5);
            check("stall_req_ready", req_ready, 2'b00);
        end
        @(posedge clk); #1 rsp_ready = 2'b01;
        @(negedge clk);
        check("consume_cycle_req_ready", req_ready, 2'b00);
        @(posedge clk); #1 rsp_ready = 2'b11;
        @(negedge clk);
        check("after_consume_req_ready", req_ready, 2'b10);
        @(posedge clk); #1 req_valid = 2'b00;
        repeat (4) @(negedge clk);

        // Reset during EXEC aborts the transaction.
        req_op0 = 4'd3; req_a0 = 32'd1; req_b0 = 32'd1;
        gnt_q.push_back(2'b01);
        @(posedge clk); #1 req_valid = 2'b01;
        wait_accept(1'b0);
        @(posedge clk); #1;
        check("exec_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_rsp_valid", rsp_valid, 2'b00);
        check("abort_req_ready", req_ready, 2'b00);
        check("abort_alu_sel", alu_sel, 4'd0);
        check("abort_alu_a", alu_a, 32'd0);
        repeat (3) @(negedge clk);
        check("abort_hold_rsp_valid", rsp_valid, 2'b00);
        req_valid = 2'b00;
        @(posedge clk); #1 rst_n = 1'b1;

        // Next request after the abort completes normally.
        req_op1 = 4'd7; req_a1 = 32'h1234; req_b1 = 32'd0;
        gnt_q.push_back(2'b10);
        rsp_q.push_back('{who: 2'b10, data: 32'h1234, err: 1'b0});
        @(posedge clk); #1 req_valid = 2'b10;
        wait_accept(1'b0);
        @(posedge clk); #1 req_valid = 2'b00;
        repeat (5) @(negedge clk);

        check("grant_queue_drained", gnt_q.size(), 0);
        check("rsp_queue_drained", rsp_q.size(), 0);
        check("grant_queue3_drained", gnt_q3.size(), 0);
        check("rsp_queue3_drained", rsp_q3.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
